// File: rtl/counter_mod_pkg.sv
// Shared definitions for the modulo up/down counter: mode encodings and
// the helper that sizes the prescaler register from the division ratio.
package counter_mod_pkg;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // Prescaler width for a ratio of div: enough bits to hold div-1, never less than 1.
  function automatic int presc_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/counter_mod_tick_gen.sv
// Prescaler: emits one enabled tick per DIV enabled cycles.
// With DIV=1 there is no state and the tick is simply the enable.
module counter_mod_tick_gen
  import counter_mod_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  generate
    if (DIV <= 1) begin : g_bypass
      // No prescaler: clock, reset and clear have nothing to act on.
      logic unused_ok;
      assign unused_ok = clk_i ^ nrst_i ^ clr_i;
      assign tick_o    = en_i;
    end else begin : g_presc
      localparam int            PW   = presc_width(DIV);
      localparam logic [PW-1:0] LAST = PW'(DIV - 1);
      localparam logic [PW-1:0] ONE  = PW'(1);

      logic [PW-1:0] presc_q;
      logic [PW-1:0] presc_d;

      // Next prescaler value: clear wins, advance only while enabled, restart after last.
      always_comb begin
        presc_d = presc_q;
        if (clr_i) begin
          presc_d = '0;
        end else if (en_i) begin
          presc_d = (presc_q == LAST) ? '0 : presc_q + ONE;
        end
      end

      // Prescaler register.
      always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
          presc_q <= '0;
        end else begin
          presc_q <= presc_d;
        end
      end

      assign tick_o = en_i & (presc_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/counter_mod.sv
// Modulo up/down counter with runtime limit, parallel load, prescaled enable,
// WRAP / ONESHOT modes, a one-cycle wrap pulse and a sticky done flag.
module counter_mod
  import counter_mod_pkg::*;
#(
  parameter int BW  = 8,
  parameter int DIV = 1
) (
  input  logic          clk_i,
  input  logic          nrst_i,
  input  logic          nrstSync_i,
  input  logic          en_i,
  input  logic          up_i,
  input  logic          mode_i,
  input  logic [BW-1:0] max_i,
  input  logic          load_i,
  input  logic [BW-1:0] loadVal_i,
  output logic [BW-1:0] count_o,
  output logic          wrap_o,
  output logic          done_o
);

  localparam logic [BW-1:0] ONE = BW'(1);

  logic          tick;
  logic          clr;
  logic          terminal;
  logic [BW-1:0] count_q;
  logic [BW-1:0] count_d;
  logic          wrap_q;
  logic          wrap_d;
  logic          done_q;
  logic          done_d;

  // Prescaler restarts on a sync clear or a load so the next step gets a full period.
  assign clr = ~nrstSync_i | load_i;

  counter_mod_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk_i  (clk_i),
    .nrst_i (nrst_i),
    .clr_i  (clr),
    .en_i   (en_i),
    .tick_o (tick)
  );

  // Terminal is checked before stepping, so the increment/decrement never overflows.
  assign terminal = up_i ? (count_q >= max_i) : (count_q == '0);

  // Next-state: clear > load > step (unless done) > hold; wrap defaults low every edge.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    done_d  = done_q;
    if (!nrstSync_i) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (load_i) begin
      count_d = loadVal_i;
      done_d  = 1'b0;
    end else if (tick && !done_q) begin
      if (terminal) begin
        if (mode_i == MODE_WRAP) begin
          count_d = up_i ? '0 : max_i;
          wrap_d  = 1'b1;
        end else begin
          done_d  = 1'b1;
        end
      end else begin
        count_d = up_i ? (count_q + ONE) : (count_q - ONE);
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = wrap_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_counter_mod.sv
// Directed bench for counter_mod: one DIV=1 and one DIV=3 instance (BW=4)
// share the same stimulus; each section checks the instance it targets.
module tb_counter_mod;
  import counter_mod_pkg::*;

  logic       clk_i = 1'b0;
  logic       nrst_i;
  logic       nrstSync_i;
  logic       en_i;
  logic       up_i;
  logic       mode_i;
  logic [3:0] max_i;
  logic       load_i;
  logic [3:0] loadVal_i;

  logic [3:0] count1;
  logic       wrap1;
  logic       done1;
  logic [3:0] count3;
  logic       wrap3;
  logic       done3;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk_i = ~clk_i;

  counter_mod #(.BW(4), .DIV(1)) u_dut1 (
    .clk_i      (clk_i),
    .nrst_i     (nrst_i),
    .nrstSync_i (nrstSync_i),
    .en_i       (en_i),
    .up_i       (up_i),
    .mode_i     (mode_i),
    .max_i      (max_i),
    .load_i     (load_i),
    .loadVal_i  (loadVal_i),
    .count_o    (count1),
    .wrap_o     (wrap1),
    .done_o     (done1)
  );

  counter_mod #(.BW(4), .DIV(3)) u_dut3 (
    .clk_i      (clk_i),
    .nrst_i     (nrst_i),
    .nrstSync_i (nrstSync_i),
    .en_i       (en_i),
    .up_i       (up_i),
    .mode_i     (mode_i),
    .max_i      (max_i),
    .load_i     (load_i),
    .loadVal_i  (loadVal_i),
    .count_o    (count3),
    .wrap_o     (wrap3),
    .done_o     (done3)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0d (t=%0t)", tag, obs, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick_clk();
    @(posedge clk_i);
    #1;
  endtask

  // Expected DIV=1 sequence for the WRAP count-up run (max=9).
  int exp_cnt1 [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
  // Expected DIV=3 count after each edge; en_i dropped on edges 8 and 9.
  int exp_cnt3 [11] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3};
  // Expected count for the load-12 count-down run.
  int exp_dn   [4]  = '{11, 10, 9, 8};

  initial begin
    nrst_i     = 1'b0;
    nrstSync_i = 1'b1;
    en_i       = 1'b0;
    up_i       = 1'b1;
    mode_i     = MODE_WRAP;
    max_i      = 4'd9;
    load_i     = 1'b0;
    loadVal_i  = 4'd0;

    // Reset state
    #2;
    check_eq("rst_count", int'(count1), 0);
    check_eq("rst_wrap",  int'(wrap1),  0);
    check_eq("rst_done",  int'(done1),  0);
    #1;
    nrst_i = 1'b1;
    en_i   = 1'b1;

    // 1: DIV=1 WRAP count up 0..9,0,1; wrap only on the count-0 cycle
    for (int i = 0; i < 11; i++) begin
      tick_clk();
      check_eq($sformatf("t1_count[%0d]", i), int'(count1), exp_cnt1[i]);
      check_eq($sformatf("t1_wrap[%0d]", i),  int'(wrap1),  (i == 9) ? 1 : 0);
    end

    // 2: ONESHOT count down from load 3, stop at 0 with done
    mode_i = MODE_ONESHOT; up_i = 1'b0; max_i = 4'd5;
    load_i = 1'b1; loadVal_i = 4'd3;
    tick_clk();
    check_eq("t2_load3", int'(count1), 3);
    load_i = 1'b0;
    tick_clk(); check_eq("t2_c2", int'(count1), 2);
    tick_clk(); check_eq("t2_c1", int'(count1), 1);
    tick_clk(); check_eq("t2_c0", int'(count1), 0);
    check_eq("t2_done_pre", int'(done1), 0);
    tick_clk();
    check_eq("t2_hold0", int'(count1), 0);
    check_eq("t2_done", int'(done1), 1);
    check_eq("t2_nowrap", int'(wrap1), 0);
    mode_i = MODE_WRAP;
    tick_clk();
    check_eq("t2_modechg_cnt",  int'(count1), 0);
    check_eq("t2_modechg_done", int'(done1), 1);
    check_eq("t2_modechg_wrap", int'(wrap1), 0);
    mode_i = MODE_ONESHOT;
    load_i = 1'b1; loadVal_i = 4'd4;
    tick_clk();
    check_eq("t2_load4", int'(count1), 4);
    check_eq("t2_done_clr", int'(done1), 0);
    load_i = 1'b0;
    tick_clk(); check_eq("t2_c3", int'(count1), 3);

    // 3: DIV=3 prescaled count up, enable dropped mid-period
    nrstSync_i = 1'b0;
    tick_clk();
    check_eq("t3_sclr", int'(count3), 0);
    nrstSync_i = 1'b1; en_i = 1'b1; up_i = 1'b1; mode_i = MODE_WRAP; max_i = 4'd15;
    for (int i = 0; i < 11; i++) begin
      en_i = (i == 7 || i == 8) ? 1'b0 : 1'b1;
      tick_clk();
      check_eq($sformatf("t3_count[%0d]", i), int'(count3), exp_cnt3[i]);
      check_eq($sformatf("t3_wrap[%0d]", i),  int'(wrap3), 0);
    end
    en_i = 1'b1;

    // 4: load above max, then wrap up / plain count down; max=0 boundary
    max_i = 4'd9; up_i = 1'b1; mode_i = MODE_WRAP;
    load_i = 1'b1; loadVal_i = 4'd12;
    tick_clk();
    check_eq("t4_load12", int'(count1), 12);
    check_eq("t4_load_nowrap", int'(wrap1), 0);
    load_i = 1'b0;
    tick_clk();
    check_eq("t4_up_wrap_cnt", int'(count1), 0);
    check_eq("t4_up_wrap", int'(wrap1), 1);
    load_i = 1'b1; up_i = 1'b0;
    tick_clk();
    check_eq("t4_reload12", int'(count1), 12);
    check_eq("t4_reload_wrap", int'(wrap1), 0);
    load_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick_clk();
      check_eq($sformatf("t4_dn[%0d]", i), int'(count1), exp_dn[i]);
      check_eq($sformatf("t4_dn_wrap[%0d]", i), int'(wrap1), 0);
    end
    max_i = 4'd0; up_i = 1'b1;
    tick_clk();
    check_eq("t4_max0_up_cnt", int'(count1), 0);
    check_eq("t4_max0_up_wrap", int'(wrap1), 1);
    tick_clk();
    check_eq("t4_max0_up2_cnt", int'(count1), 0);
    check_eq("t4_max0_up2_wrap", int'(wrap1), 1);
    up_i = 1'b0;
    tick_clk();
    check_eq("t4_max0_dn_cnt", int'(count1), 0);
    check_eq("t4_max0_dn_wrap", int'(wrap1), 1);

    // 5: clear beats load; load beats a wrapping step
    max_i = 4'd9; up_i = 1'b1;
    nrstSync_i = 1'b0; load_i = 1'b1; loadVal_i = 4'd7;
    tick_clk();
    check_eq("t5_clr_wins", int'(count1), 0);
    check_eq("t5_clr_wrap", int'(wrap1), 0);
    nrstSync_i = 1'b1; loadVal_i = 4'd9;
    tick_clk();
    check_eq("t5_load9", int'(count1), 9);
    loadVal_i = 4'd5;
    tick_clk();
    check_eq("t5_load_on_step", int'(count1), 5);
    check_eq("t5_load_nowrap", int'(wrap1), 0);
    load_i = 1'b0;

    // 6: asynchronous reset mid-count, then restart with a full DIV period
    tick_clk();
    tick_clk();
    #2;
    nrst_i = 1'b0;
    #1;
    check_eq("t6_async_cnt1", int'(count1), 0);
    check_eq("t6_async_cnt3", int'(count3), 0);
    check_eq("t6_async_wrap", int'(wrap1), 0);
    check_eq("t6_async_done", int'(done1), 0);
    #2;
    nrst_i = 1'b1;
    tick_clk();
    check_eq("t6_e1_cnt1", int'(count1), 1);
    check_eq("t6_e1_cnt3", int'(count3), 0);
    tick_clk();
    check_eq("t6_e2_cnt3", int'(count3), 0);
    tick_clk();
    check_eq("t6_e3_cnt3", int'(count3), 1);
    check_eq("t6_e3_cnt1", int'(count1), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
